// File: rtl/layers_mosi_dispatcher_if.sv
// Host byte stream plus per-layer MOSI AXI-Stream bundle for layers_mosi_dispatcher.
// master: the dispatcher side (consumes the host stream, drives the layer streams).
// slave : the environment side (host source and layer sinks).
interface layers_mosi_dispatcher_if #(
    parameter int unsigned LAYER_COUNT = 5
);
    logic [7:0]               s_axis_tdata;
    logic                     s_axis_tvalid;
    logic                     s_axis_tlast;
    logic                     s_axis_tready;
    logic [LAYER_COUNT*8-1:0] layers_mosi_m_axis_tdata;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tvalid;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tlast;
    logic [LAYER_COUNT-1:0]   layers_mosi_m_axis_tready;

    modport master (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready,
        output layers_mosi_m_axis_tdata,
        output layers_mosi_m_axis_tvalid,
        output layers_mosi_m_axis_tlast,
        input  layers_mosi_m_axis_tready
    );

    modport slave (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready,
        input  layers_mosi_m_axis_tdata,
        input  layers_mosi_m_axis_tvalid,
        input  layers_mosi_m_axis_tlast,
        output layers_mosi_m_axis_tready
    );
endinterface

// File: rtl/layers_mosi_dispatcher.sv
// Splits a framed host byte stream (ID, LEN_HI, LEN_LO, payload) onto per-layer MOSI streams.
// Payload is a zero-latency combinational pass-through to the selected layer(s).
// Optional: define LAYERS_MOSI_DISPATCH_BROADCAST_EN to make ID 0xFF address every
// non-disabled layer; otherwise 0xFF is an invalid ID.
module layers_mosi_dispatcher #(
    parameter int unsigned LAYER_COUNT = 5
) (
    input  logic                   clk_core,
    input  logic                   clk_core_resn,
    layers_mosi_dispatcher_if.master bus,
    input  logic [LAYER_COUNT-1:0] config_layers_disable,
    output logic                   status_busy,
    output logic [7:0]             status_current_layer,
    output logic [LAYER_COUNT-1:0] stat_frame_dispatched,
    output logic                   stat_err_bad_dest,
    output logic                   stat_err_truncated
);

    typedef enum logic [2:0] {
        StHdrId,
        StHdrLenHi,
        StHdrLenLo,
        StPayload,
        StDrop
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [7:0]             r_dest;
    logic [7:0]             w_dest_next;
    logic [7:0]             r_len_hi;
    logic [7:0]             w_len_hi_next;
    logic [15:0]            r_remaining;
    logic [15:0]            w_remaining_next;
    logic [LAYER_COUNT-1:0] r_sel;
    logic [LAYER_COUNT-1:0] w_sel_next;
    logic [LAYER_COUNT-1:0] r_dispatched;
    logic [LAYER_COUNT-1:0] w_dispatched_next;
    logic                   r_active;
    logic [LAYER_COUNT-1:0] w_sel_mask;
    logic                   w_s_tready;
    logic [LAYER_COUNT-1:0] w_m_tvalid;
    logic [LAYER_COUNT-1:0] w_m_tlast;
    logic                   w_bad_dest;
    logic                   w_trunc;
    logic                   w_last_byte;
    logic [15:0]            w_len;

    // Layer selection decoded from the latched ID, masked by the disable vector.
    always_comb begin
        w_sel_mask = '0;
        for (int unsigned li = 0; li < LAYER_COUNT; li++) begin
            if (r_dest == 8'(li + 1)) begin
                w_sel_mask[li] = 1'b1;
            end
        end
`ifdef LAYERS_MOSI_DISPATCH_BROADCAST_EN
        if (r_dest == 8'hFF) begin
            w_sel_mask = '1;
        end
`endif
        w_sel_mask = w_sel_mask & ~config_layers_disable;
    end

    assign w_len       = {r_len_hi, bus.s_axis_tdata};
    assign w_last_byte = (r_remaining == 16'd1) || bus.s_axis_tlast;

    // Next-state, handshake and stream routing.
    always_comb begin
        w_state_next      = r_state;
        w_dest_next       = r_dest;
        w_len_hi_next     = r_len_hi;
        w_remaining_next  = r_remaining;
        w_sel_next        = r_sel;
        w_dispatched_next = '0;
        w_bad_dest        = 1'b0;
        w_trunc           = 1'b0;
        w_s_tready        = 1'b0;
        w_m_tvalid        = '0;
        w_m_tlast         = '0;
        unique case (r_state)
            StHdrId: begin
                // r_active keeps tready low while reset is asserted
                w_s_tready = r_active;
                if (bus.s_axis_tvalid && w_s_tready) begin
                    w_dest_next  = bus.s_axis_tdata;
                    w_state_next = StHdrLenHi;
                end
            end
            StHdrLenHi: begin
                w_s_tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    w_len_hi_next = bus.s_axis_tdata;
                    w_state_next  = StHdrLenLo;
                end
            end
            StHdrLenLo: begin
                w_s_tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    w_remaining_next = w_len;
                    if (w_len == 16'd0) begin
                        w_state_next = StHdrId;
                    end else if (|w_sel_mask) begin
                        w_sel_next   = w_sel_mask;
                        w_state_next = StPayload;
                    end else begin
                        w_sel_next   = '0;
                        w_bad_dest   = 1'b1;
                        w_state_next = StDrop;
                    end
                end
            end
            StPayload: begin
                // Host waits until every selected layer is ready
                w_s_tready = &(bus.layers_mosi_m_axis_tready | ~r_sel);
                w_m_tvalid = r_sel & {LAYER_COUNT{bus.s_axis_tvalid}};
                w_m_tlast  = r_sel & {LAYER_COUNT{w_last_byte}};
                if (bus.s_axis_tvalid && w_s_tready) begin
                    w_remaining_next = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_dispatched_next = r_sel;
                        w_state_next      = StHdrId;
                    end else if (bus.s_axis_tlast) begin
                        w_trunc      = 1'b1;
                        w_state_next = StHdrId;
                    end
                end
            end
            StDrop: begin
                w_s_tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    w_remaining_next = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        w_state_next = StHdrId;
                    end else if (bus.s_axis_tlast) begin
                        w_trunc      = 1'b1;
                        w_state_next = StHdrId;
                    end
                end
            end
            default: begin
                w_state_next = StHdrId;
            end
        endcase
    end

    // State and frame context registers.
    always_ff @(posedge clk_core or negedge clk_core_resn) begin
        if (!clk_core_resn) begin
            r_state      <= StHdrId;
            r_dest       <= 8'd0;
            r_len_hi     <= 8'd0;
            r_remaining  <= 16'd0;
            r_sel        <= '0;
            r_dispatched <= '0;
            r_active     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dest       <= w_dest_next;
            r_len_hi     <= w_len_hi_next;
            r_remaining  <= w_remaining_next;
            r_sel        <= w_sel_next;
            r_dispatched <= w_dispatched_next;
            r_active     <= 1'b1;
        end
    end

    // Unselected lanes carry the same byte but never assert tvalid.
    assign bus.layers_mosi_m_axis_tdata  = {LAYER_COUNT{bus.s_axis_tdata}};
    assign bus.layers_mosi_m_axis_tvalid = w_m_tvalid;
    assign bus.layers_mosi_m_axis_tlast  = w_m_tlast;
    assign bus.s_axis_tready             = w_s_tready;

    assign status_busy           = (r_state != StHdrId);
    assign status_current_layer  = (r_state == StHdrId) ? 8'd0 : r_dest;
    assign stat_frame_dispatched = r_dispatched;
    assign stat_err_bad_dest     = w_bad_dest;
    assign stat_err_truncated    = w_trunc;

endmodule

// File: tb/tb_layers_mosi_dispatcher.sv
// Directed, table-driven bench for layers_mosi_dispatcher (LAYER_COUNT = 5).
module tb_layers_mosi_dispatcher;

    localparam int unsigned N = 5;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] cfg_dis;
    logic         busy;
    logic [7:0]   cur_layer;
    logic [N-1:0] disp;
    logic         bad_dest;
    logic         trunc;

    int n_checks;
    int n_errors;

    layers_mosi_dispatcher_if #(.LAYER_COUNT(N)) bus ();

    layers_mosi_dispatcher #(.LAYER_COUNT(N)) dut (
        .clk_core              (clk),
        .clk_core_resn         (rst_n),
        .bus                   (bus),
        .config_layers_disable (cfg_dis),
        .status_busy           (busy),
        .status_current_layer  (cur_layer),
        .stat_frame_dispatched (disp),
        .stat_err_bad_dest     (bad_dest),
        .stat_err_truncated    (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   d;
        logic         last;
        logic [N-1:0] rdy;
        logic [N-1:0] dis;
        logic         exp_srdy;
        logic [N-1:0] exp_tv;
        logic [N-1:0] exp_tl;
        logic [N-1:0] exp_disp;
        logic         exp_bad;
        logic         exp_trunc;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [N-1:0] A = 5'h1F;

`ifdef LAYERS_MOSI_DISPATCH_BROADCAST_EN
    localparam logic         BC = 1'b1;
`else
    localparam logic         BC = 1'b0;
`endif

    function automatic void add(input logic [7:0] d, input logic last, input logic [N-1:0] rdy,
                                input logic [N-1:0] dis, input logic srdy, input logic [N-1:0] tv,
                                input logic [N-1:0] tl, input logic [N-1:0] dp, input logic bad,
                                input logic tr, input logic bsy);
        vec_t v;
        v.d = d; v.last = last; v.rdy = rdy; v.dis = dis; v.exp_srdy = srdy; v.exp_tv = tv;
        v.exp_tl = tl; v.exp_disp = dp; v.exp_bad = bad; v.exp_trunc = tr; v.exp_busy = bsy;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one host byte after the rising edge, compare at the falling edge.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        logic  lane_ok;
        @(posedge clk);
        #1;
        bus.s_axis_tdata              = v.d;
        bus.s_axis_tvalid             = 1'b1;
        bus.s_axis_tlast              = v.last;
        bus.layers_mosi_m_axis_tready = v.rdy;
        cfg_dis                       = v.dis;
        @(negedge clk);
        tag = $sformatf("row%0d", idx);
        check({tag, " s_tready"}, 32'(bus.s_axis_tready), 32'(v.exp_srdy));
        check({tag, " m_tvalid"}, 32'(bus.layers_mosi_m_axis_tvalid), 32'(v.exp_tv));
        check({tag, " m_tlast"}, 32'(bus.layers_mosi_m_axis_tlast & v.exp_tv), 32'(v.exp_tl));
        check({tag, " dispatched"}, 32'(disp), 32'(v.exp_disp));
        check({tag, " bad_dest"}, 32'(bad_dest), 32'(v.exp_bad));
        check({tag, " truncated"}, 32'(trunc), 32'(v.exp_trunc));
        check({tag, " busy"}, 32'(busy), 32'(v.exp_busy));
        if (v.exp_tv != '0) begin
            lane_ok = 1'b1;
            for (int li = 0; li < int'(N); li++) begin
                if (v.exp_tv[li] && bus.layers_mosi_m_axis_tdata[li*8 +: 8] !== v.d) begin
                    lane_ok = 1'b0;
                end
            end
            check({tag, " m_tdata"}, 32'(lane_ok), 32'd1);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " s_tready"}, 32'(bus.s_axis_tready), 32'd0);
        check({name, " m_tvalid"}, 32'(bus.layers_mosi_m_axis_tvalid), 32'd0);
        check({name, " m_tlast"}, 32'(bus.layers_mosi_m_axis_tlast), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " cur_layer"}, 32'(cur_layer), 32'd0);
        check({name, " pulses"}, {29'd0, 32'(disp) != 0, bad_dest, trunc}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        cfg_dis = '0;
        bus.s_axis_tdata = 8'h00;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast = 1'b0;
        bus.layers_mosi_m_axis_tready = A;

        // Args: data, last, rdy, dis, exp s_tready, tvalid, tlast, dispatched, bad, trunc, busy
        // 1: three bytes to layer 2
        add(8'h02, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h03, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'hAA, 0, A, 0, 1, 5'h02, 5'h00, 5'h00, 0, 0, 1);
        add(8'hBB, 0, A, 0, 1, 5'h02, 5'h00, 5'h00, 0, 0, 1);
        add(8'hCC, 0, A, 0, 1, 5'h02, 5'h02, 5'h00, 0, 0, 1);
        // 2: layer 1 stalls for 5 cycles; disabling it mid-frame has no effect
        add(8'h01, 0, A, 0, 1, 5'h00, 5'h00, 5'h02, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h04, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h11, 0, A, 0, 1, 5'h01, 5'h00, 5'h00, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            add(8'h22, 0, 5'h1E, 5'h01, 0, 5'h01, 5'h00, 5'h00, 0, 0, 1);
        end
        add(8'h22, 0, A, 0, 1, 5'h01, 5'h00, 5'h00, 0, 0, 1);
        add(8'h33, 0, A, 0, 1, 5'h01, 5'h00, 5'h00, 0, 0, 1);
        add(8'h44, 0, A, 0, 1, 5'h01, 5'h01, 5'h00, 0, 0, 1);
        // 3: invalid ID 7 dropped, then one byte to layer 3 with tlast on the final byte
        add(8'h07, 0, A, 0, 1, 5'h00, 5'h00, 5'h01, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h02, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 1, 0, 1);
        add(8'h55, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h66, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h03, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h01, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h77, 1, A, 0, 1, 5'h04, 5'h04, 5'h00, 0, 0, 1);
        // 4: truncated frame to layer 4, then zero-length header with ignored tlast
        add(8'h04, 0, A, 0, 1, 5'h00, 5'h00, 5'h04, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h05, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h01, 0, A, 0, 1, 5'h08, 5'h00, 5'h00, 0, 0, 1);
        add(8'h02, 1, A, 0, 1, 5'h08, 5'h08, 5'h00, 0, 1, 1);
        add(8'h05, 1, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0);
        add(8'h00, 1, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        // 5: frame to disabled layer 2 dropped
        add(8'h02, 0, A, 5'h02, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0);
        add(8'h00, 0, A, 5'h02, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h01, 0, A, 5'h02, 1, 5'h00, 5'h00, 5'h00, 1, 0, 1);
        add(8'h99, 0, A, 5'h02, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        // 6: ID 0xFF, broadcast when enabled, otherwise dropped
        add(8'hFF, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h02, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, !BC, 0, 1);
        add(8'hDE, 0, A, 0, 1, BC ? A : 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'hAD, 0, A, 0, 1, BC ? A : 5'h00, BC ? A : 5'h00, 5'h00, 0, 0, 1);
        // Zero-length frame with ID 0 returns to idle
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, BC ? A : 5'h00, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], i);
        end

        // Reset in the middle of a payload to layer 1
        vecs.delete();
        add(8'h01, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h03, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'hA0, 0, A, 0, 1, 5'h01, 5'h00, 5'h00, 0, 0, 1);
        apply(vecs[0], 100);
        apply(vecs[1], 101);
        check("cur_layer hdr", 32'(cur_layer), 32'd1);
        apply(vecs[2], 102);
        apply(vecs[3], 103);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("midreset hold");
        rst_n = 1'b1;

        // Next byte after reset is a header ID
        vecs.delete();
        add(8'h03, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 0);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h01, 0, A, 0, 1, 5'h00, 5'h00, 5'h00, 0, 0, 1);
        add(8'h5A, 0, A, 0, 1, 5'h04, 5'h04, 5'h00, 0, 0, 1);
        add(8'h00, 0, A, 0, 1, 5'h00, 5'h00, 5'h04, 0, 0, 0);
        foreach (vecs[i]) begin
            apply(vecs[i], 200 + i);
        end

        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/layers_mosi_dispatcher.md
Name: layers_mosi_dispatcher

Overview:
Host-to-layers command path. Takes one framed byte stream from the host register/FIFO side and splits it into the per-layer MOSI AXI-Stream inputs of the layer interfaces. Each frame is a 3-byte header followed by the payload: destination layer ID, then a 16-bit payload length (MSB first). The block is the split counterpart of the layer-frame merge switch on the MISO side.

Parameters:
LAYER_COUNT, 5, number of layer MOSI outputs; valid layer IDs are 1..LAYER_COUNT.

Ports:
clk_core  in  1  core clock; all logic on this clock
clk_core_resn  in  1  asynchronous active-low reset
s_axis_tdata  in  8  host command byte
s_axis_tvalid  in  1  host byte valid
s_axis_tlast  in  1  host end-of-burst marker
s_axis_tready  out  1  block accepts host byte
layers_mosi_m_axis_tdata  out  LAYER_COUNT*8  per-layer byte; layer li (ID li+1) owns bits [li*8+7:li*8]
layers_mosi_m_axis_tvalid  out  LAYER_COUNT  per-layer valid
layers_mosi_m_axis_tlast  out  LAYER_COUNT  per-layer last payload byte
layers_mosi_m_axis_tready  in  LAYER_COUNT  per-layer ready
config_layers_disable  in  LAYER_COUNT  frames addressed to a disabled layer are dropped
status_busy  out  1  high in any state other than HDR_ID
status_current_layer  out  8  latched destination ID of the frame in progress; 0 when idle
stat_frame_dispatched  out  LAYER_COUNT  1-cycle pulse per frame fully delivered to that layer
stat_err_bad_dest  out  1  1-cycle pulse when a frame is dropped (invalid ID or disabled layer)
stat_err_truncated  out  1  1-cycle pulse when host tlast arrives before payload end

Behaviour:
- Reset state (asynchronous, clk_core_resn low):
  - FSM is in HDR_ID; dest and remaining-length registers are 0.
  - All tvalid/tlast outputs are 0; s_axis_tready is 0 during reset.
  - status_busy = 0, status_current_layer = 0, all stat pulses = 0.
  - Reset mid-frame discards the frame; the next byte after reset is parsed as a header ID.
- FSM states: HDR_ID, HDR_LEN_HI, HDR_LEN_LO, PAYLOAD, DROP.
  - HDR_ID: s_axis_tready = 1. On handshake, latch dest = tdata and go to HDR_LEN_HI.
  - HDR_LEN_HI: s_axis_tready = 1. On handshake, latch len[15:8].
  - HDR_LEN_LO: s_axis_tready = 1. On handshake, latch len[7:0].
    - If len == 0: return to HDR_ID. No output, no dispatched pulse.
    - Else if dest is in 1..LAYER_COUNT and that layer is not disabled: go to PAYLOAD.
    - Else: go to DROP and pulse stat_err_bad_dest in the same cycle.
  - PAYLOAD: combinational pass-through, zero latency.
    - m tvalid[dest-1] = s_axis_tvalid; m tdata[dest-1] = s_axis_tdata; s_axis_tready = m tready[dest-1].
    - Every other layer's tvalid is 0.
    - Each handshake decrements remaining.
    - The byte handshaken when remaining == 1 carries m tlast = 1. The FSM then returns to HDR_ID and stat_frame_dispatched[dest-1] pulses in the next cycle.
  - DROP: s_axis_tready = 1. Bytes are consumed and discarded, decrementing remaining. Return to HDR_ID after the last byte.
- Header fields are 16-bit unsigned; maximum payload is 65535 bytes. config_layers_disable is sampled only in HDR_LEN_LO.
- Truncation: s_axis_tlast handshaken in PAYLOAD or DROP before remaining reaches 1:
  - That byte is forwarded with m tlast = 1 (PAYLOAD only).
  - stat_err_truncated pulses and the FSM returns to HDR_ID.
  - No dispatched pulse is issued.
- s_axis_tlast during header states is ignored.
- A tlast coincident with the final payload byte is a normal completion, not a truncation.
- Changing config_layers_disable mid-PAYLOAD does not affect the frame in progress.
- A layer's tready low stalls the host (backpressure); other layers are unaffected. Bytes are never duplicated or lost under stall.

Optional Feature:
Macro LAYERS_MOSI_DISPATCH_BROADCAST_EN.
- Defined: dest ID 0xFF means broadcast to every non-disabled layer.
  - All selected tvalid bits equal s_axis_tvalid.
  - s_axis_tready is the AND of the selected treadys.
  - tlast is on all selected layers.
  - dispatched pulses on all selected layers.
  - If every layer is disabled, the frame takes the DROP path.
- Undefined: 0xFF is an invalid ID and is dropped with stat_err_bad_dest.

Test Plan:
1. Host sends 02 00 03 AA BB CC, all readies high -> layer 2 outputs AA, BB, CC with tlast on CC; stat_frame_dispatched[1] pulses once; other layers' tvalid stay 0.
2. Host sends 01 00 04 11 22 33 44 with layer 1 tready low for 5 cycles after the first byte -> s_axis_tready low in those cycles; layer 1 receives exactly 11 22 33 44, tlast on 44.
3. Host sends 07 00 02 55 66 (LAYER_COUNT = 5), then 03 00 01 77 -> stat_err_bad_dest pulses once; no output for 55, 66; layer 3 then receives 77 with tlast.
4. Host sends 04 00 05 01 02 with s_axis_tlast on 02 -> layer 4 receives 01, 02 with tlast on 02; stat_err_truncated pulses; next byte 05 00 00 is parsed as a header (zero length, no output).
5. Set config_layers_disable = 5'b00010, host sends 02 00 01 99 -> frame dropped, stat_err_bad_dest pulses; assert reset mid-payload of 01 00 03 A0 A1 -> after release all outputs are 0 and the next frame is parsed from its header.
6. With LAYERS_MOSI_DISPATCH_BROADCAST_EN defined, host sends FF 00 02 DE AD -> all 5 layers receive DE AD, and tlast on AD for each layer.
